// File: rtl/ndata_serializer.sv
// ndata_serializer: turns N-lane keep-masked beats into one element per cycle,
// lowest kept lane first, with keep=0/last=1 beats emitted as an empty terminator.
module ndata_serializer #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] in_data,
  input  logic [NUM_ELEMENTS-1:0]            in_keep,
  input  logic                               in_last,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_keep,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready
);
  typedef enum logic [1:0] {EMPTY, STREAM, TERM} state_e;
  state_e                             state_q;
  logic [DATA_WIDTH*NUM_ELEMENTS-1:0] data_q;
  logic                               last_q;
  logic [NUM_ELEMENTS-1:0]            rem_q;
  logic [NUM_ELEMENTS-1:0]            rem_dec;
  logic [NUM_ELEMENTS-1:0]            low;
  logic [DATA_WIDTH-1:0]              lane;
  logic                               one_left;
  logic                               fin;
  logic                               acc;
  assign rem_dec  = rem_q - NUM_ELEMENTS'(1);
  assign low      = rem_q & ~rem_dec;
  assign one_left = (rem_q & rem_dec) == '0;
  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++)
      lane = lane | (low[i] ? data_q[i*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  // fin: the last element of the held beat leaves now, so a new beat may load in the same cycle
  assign fin       = out_ready && (state_q == TERM || (state_q == STREAM && one_left));
  assign in_ready  = rst_n && (state_q == EMPTY || fin);
  assign acc       = in_valid && in_ready;
  assign out_valid = state_q != EMPTY;
  assign out_keep  = state_q == STREAM;
  assign out_last  = state_q == TERM || (state_q == STREAM && last_q && one_left);
  assign out_data  = state_q == STREAM ? lane : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      last_q  <= 1'b0;
      rem_q   <= '0;
    end else if (acc && in_keep != '0) begin
      state_q <= STREAM;
      data_q  <= in_data;
      last_q  <= in_last;
      rem_q   <= in_keep;
    end else if (acc) begin
      state_q <= in_last ? TERM : EMPTY;
      rem_q   <= '0;
    end else if (fin) begin
      state_q <= EMPTY;
      rem_q   <= '0;
    end else if (out_valid && out_ready) begin
      rem_q   <= rem_q & ~low;
    end
  end
endmodule
